branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, next-PC override and mispredict recovery.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        gated_clock_PC,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        pcsrc,
  output logic [31:0] br_target,
  output logic        pred_taken,
  output logic [31:0] pred_target,
`ifdef BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        IF_ID_flush
);

  localparam int IB = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IB;

  logic             r_valid  [BTB_ENTRIES];
  logic [1:0]       r_ctr    [BTB_ENTRIES];
  logic [TW-1:0]    r_tag    [BTB_ENTRIES];
  logic [31:0]      r_target [BTB_ENTRIES];

  logic [IB-1:0] w_fidx;
  logic [IB-1:0] w_uidx;
  logic [TW-1:0] w_ftag;
  logic [TW-1:0] w_utag;
  logic          w_fhit;
  logic          w_uhit;
  logic          w_mispredict;
  logic          w_unused;

  assign w_fidx   = fetch_pc[IB+1:2];
  assign w_ftag   = fetch_pc[31:IB+2];
  assign w_uidx   = upd_pc[IB+1:2];
  assign w_utag   = upd_pc[31:IB+2];
  assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Lookup reads pre-update contents; a same-cycle write shows up after the edge.
  assign w_fhit      = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign pred_taken  = w_fhit && r_ctr[w_fidx][1];
  assign pred_target = w_fhit ? r_target[w_fidx] : (fetch_pc + 32'd4);

  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  assign w_mispredict = upd_valid &
                        ((upd_taken != upd_pred_taken) |
                         (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));

  always_comb begin
    pcsrc       = pred_taken;
    br_target   = pred_target;
    IF_ID_flush = 1'b0;
    if (w_mispredict) begin
      pcsrc       = 1'b1;
      IF_ID_flush = 1'b1;
      br_target   = upd_taken ? upd_target : (upd_pc + 32'd4);
    end
  end

  // upd_* are held stable by EX while the PC stalls, so one update lands per gated edge.
  always_ff @(posedge gated_clock_PC or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_uhit) begin
        if (upd_taken) begin
          if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
        end else begin
          if (r_ctr[w_uidx] != 2'b00) r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; they are meaningless while the valid bit is clear.
  always_ff @(posedge gated_clock_PC) begin
    if (!rst && upd_valid && upd_taken) begin
      r_target[w_uidx] <= upd_target;
      if (!w_uhit) r_tag[w_uidx] <= w_utag;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge gated_clock_PC or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      if (upd_valid)    r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  // Statistics build option disabled: no stat ports or counters.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table, stall, wrap and reset sequences.
// Stat checks are compiled in when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk;
  logic        pc_write;
  logic        gated_clock_PC;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        pcsrc;
  logic [31:0] br_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        IF_ID_flush;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  int          exp_branches;
  int          exp_mispredicts;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [31:0] fetch_pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_pcsrc;
    logic [31:0] e_br;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_flush;
  } vec_t;

  logic [66:0] exp_q[$];
  vec_t        vecs[16];

  // clock / reset block; PC stalls are modelled by gating the free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign gated_clock_PC = clk & pc_write;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_predictor #(.BTB_ENTRIES(16)) dut (
    .gated_clock_PC (gated_clock_PC),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .pcsrc          (pcsrc),
    .br_target      (br_target),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
`ifdef BP_STATS_EN
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .IF_ID_flush    (IF_ID_flush)
  );

  function automatic vec_t mk(logic [31:0] f, logic uv, logic [31:0] upc, logic ut,
                              logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                              logic ep, logic [31:0] eb, logic et, logic [31:0] etg,
                              logic ef);
    vec_t v;
    v.fetch_pc = f;   v.uv = uv;       v.upc = upc;   v.ut = ut;
    v.utgt = utgt;    v.upt = upt;     v.uptgt = uptgt;
    v.e_pcsrc = ep;   v.e_br = eb;     v.e_pt = et;   v.e_ptgt = etg;
    v.e_flush = ef;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(vec_t v);
    exp_q.push_back({v.e_pcsrc, v.e_br, v.e_pt, v.e_ptgt, v.e_flush});
  endtask

  // scoreboard: pop the oldest expectation and compare against live outputs
  task automatic check_outputs(string tag);
    logic [66:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.queue: got empty expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".pcsrc"},       32'(pcsrc),       32'(e[66]));
    cmp({tag, ".br_target"},   br_target,        e[65:34]);
    cmp({tag, ".pred_taken"},  32'(pred_taken),  32'(e[33]));
    cmp({tag, ".pred_target"}, pred_target,      e[32:1]);
    cmp({tag, ".IF_ID_flush"}, 32'(IF_ID_flush), 32'(e[0]));
  endtask

  task automatic drive(vec_t v);
    fetch_pc        = v.fetch_pc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
  endtask

  // one PC cycle: drive on the falling edge, check 1 time unit later, edge follows if pw=1
  task automatic step(vec_t v, logic pw, string tag);
    @(negedge clk);
    pc_write = pw;
    drive(v);
    push_exp(v);
`ifdef BP_STATS_EN
    if (pw && v.uv && !rst) begin
      exp_branches++;
      if (v.e_flush) exp_mispredicts++;
    end
`endif
    #1;
    check_outputs(tag);
  endtask

  task automatic check_stats(string tag);
`ifdef BP_STATS_EN
    cmp({tag, ".stat_branches"},    stat_branches,    32'(exp_branches));
    cmp({tag, ".stat_mispredicts"}, stat_mispredicts, 32'(exp_mispredicts));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    logic [31:0] rpc;
    checks   = 0;
    failures = 0;
`ifdef BP_STATS_EN
    exp_branches    = 0;
    exp_mispredicts = 0;
`endif
    pc_write = 1'b1;
    rst      = 1'b1;
    drive(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset state: no learned entries, next PC is fetch_pc+4
    repeat (2) @(negedge clk);
    push_exp(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h44, 0));
    #1;
    check_outputs("reset");
    check_stats("reset");
    @(negedge clk);
    rst = 1'b0;

    // vector table: train 0x40, counter walk, aliasing at 0x80, target change, PC wrap
    vecs[0]  = mk(32'h40, 0, 0,     0, 0,      0, 0,      0, 32'h44,  0, 32'h44,  0);
    vecs[1]  = mk(32'h44, 1, 32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100, 0, 32'h48,  1);
    vecs[2]  = mk(32'h40, 0, 0,     0, 0,      0, 0,      1, 32'h100, 1, 32'h100, 0);
    vecs[3]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0);
    vecs[4]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0);
    vecs[5]  = mk(32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0);
    vecs[6]  = mk(32'h40, 1, 32'h40, 0, 0,      1, 32'h100, 1, 32'h44,  1, 32'h100, 1);
    vecs[7]  = mk(32'h40, 1, 32'h40, 0, 0,      1, 32'h100, 1, 32'h44,  1, 32'h100, 1);
    vecs[8]  = mk(32'h40, 0, 0,     0, 0,      0, 0,      0, 32'h100, 0, 32'h100, 0);
    vecs[9]  = mk(32'h80, 1, 32'h40, 1, 32'h100, 0, 32'h44, 1, 32'h100, 0, 32'h84,  1);
    vecs[10] = mk(32'h80, 1, 32'h80, 0, 0,      0, 32'h84, 0, 32'h84,  0, 32'h84,  0);
    vecs[11] = mk(32'h40, 0, 0,     0, 0,      0, 0,      1, 32'h100, 1, 32'h100, 0);
    vecs[12] = mk(32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h100, 1, 32'h200, 1, 32'h100, 1);
    vecs[13] = mk(32'h40, 0, 0,     0, 0,      0, 0,      1, 32'h200, 1, 32'h200, 0);
    vecs[14] = mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h8, 1, 32'h0, 0, 32'h0, 1);
    vecs[15] = mk(32'hFFFF_FFFC, 0, 0, 0, 0,   0, 0,      0, 32'h0,   0, 32'h0,   0);
    for (int i = 0; i < 16; i++) step(vecs[i], 1'b1, $sformatf("v%0d", i));
    check_stats("table");

    // random fetches into never-trained indices 1..7 must miss
    for (int i = 0; i < 4; i++) begin
      rpc = {$urandom_range(0, 32'h3FF_FFFF), 6'b0} | (32'($urandom_range(1, 7)) << 2);
      step(mk(rpc, 0, 0, 0, 0, 0, 0, 0, rpc + 32'd4, 0, rpc + 32'd4, 0), 1'b1,
           $sformatf("rand%0d", i));
    end

    // stall: update held 3 cycles without edges, then exactly one edge applies it
    for (int i = 0; i < 3; i++) begin
      step(mk(32'h60, 1, 32'h60, 1, 32'h300, 0, 32'h64, 1, 32'h300, 0, 32'h64, 1), 1'b0,
           $sformatf("stall%0d", i));
      check_stats($sformatf("stall%0d", i));
    end
    step(mk(32'h60, 1, 32'h60, 1, 32'h300, 0, 32'h64, 1, 32'h300, 0, 32'h64, 1), 1'b1, "stall_rel");
    step(mk(32'h60, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 32'h300, 0), 1'b1, "stall_alloc");
    check_stats("stall_rel");
    // a single not-taken update drops a freshly allocated 10 to 01; a double-apply would leave it taken
    step(mk(32'h60, 1, 32'h60, 0, 0, 1, 32'h300, 1, 32'h64, 1, 32'h300, 1), 1'b1, "stall_nt");
    step(mk(32'h60, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 32'h300, 0), 1'b1, "stall_once");

    // reset between edges after training, with an update pending across the reset
    step(mk(32'h40, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h200, 0), 1'b1, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push_exp(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h44, 0));
    check_outputs("mid_rst");
`ifdef BP_STATS_EN
    exp_branches    = 0;
    exp_mispredicts = 0;
`endif
    check_stats("mid_rst");
    upd_valid      = 1'b1;
    upd_pc         = 32'h40;
    upd_taken      = 1'b1;
    upd_target     = 32'h500;
    upd_pred_taken = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 32'h44, 0), 1'b1, "post_rst");
    check_stats("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
